// File: rtl/iccm_bank_read_arbiter.sv
// iccm_bank_read_arbiter: shares one ICCM bank read port between fetch and DMA, returning an address-selected slice
// Ports: clk/rst (sync, active-high); fetch_req_* and dma_req_* valid/ready/addr request channels;
// bank_rd_en/bank_addr/bank_dout bank read port (1-cycle latency); rsp_valid/rsp_ready/rsp_id/rsp_data response channel.
module iccm_bank_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DOUT_W = 12,
  parameter int SLICE_W = 6,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req_valid,
  output logic               fetch_req_ready,
  input  logic [ADDR_W-1:0]  fetch_req_addr,
  input  logic               dma_req_valid,
  output logic               dma_req_ready,
  input  logic [ADDR_W-1:0]  dma_req_addr,
  output logic               bank_rd_en,
  output logic [ADDR_W-3:0]  bank_addr,
  input  logic [DOUT_W-1:0]  bank_dout,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [SLICE_W-1:0] rsp_data,
  input  logic               rsp_ready
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam int OW = $clog2(DOUT_W);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] starve_cnt;
  logic [1:0] iccm_rw_addr_q;
  logic [ADDR_W-3:0] row_q;
  logic id_q;
  logic [SLICE_W-1:0] data_q;
  logic dma_win, fetch_win, grant;
  logic [OW-1:0] off;
  always_comb begin
    // Grants are suppressed while rst is high so no request is accepted and then dropped.
    dma_win = state == IDLE && !rst && dma_req_valid && (!fetch_req_valid || starve_cnt == CW'(STARVE_MAX));
    fetch_win = state == IDLE && !rst && fetch_req_valid && !dma_win;
    grant = dma_win || fetch_win;
    fetch_req_ready = fetch_win;
    dma_req_ready = dma_win;
    bank_rd_en = state == ISSUE;
    bank_addr = bank_rd_en ? row_q : '0;
    rsp_valid = state == RESP;
    rsp_id = rsp_valid && id_q;
    rsp_data = rsp_valid ? data_q : '0;
    off = OW'({iccm_rw_addr_q, 1'b0});
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant ? ISSUE : IDLE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = RESP;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve_cnt <= '0;
      iccm_rw_addr_q <= '0;
      row_q <= '0;
      id_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        iccm_rw_addr_q <= dma_win ? dma_req_addr[1:0] : fetch_req_addr[1:0];
        row_q <= dma_win ? dma_req_addr[ADDR_W-1:2] : fetch_req_addr[ADDR_W-1:2];
        id_q <= dma_win;
      end
      // Only fetch wins against a waiting DMA count toward starvation.
      if (dma_win)
        starve_cnt <= '0;
      else if (fetch_win && dma_req_valid && starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + CW'(1);
      if (state == CAPTURE)
        data_q <= bank_dout[off +: SLICE_W];
    end
  end
endmodule
